// File: rtl/wt931_pkg.sv
// Shared constants, state encoding, frame buffer layout and field helpers
// for the WT931 frame controller.
package wt931_pkg;

    localparam logic [7:0] WT931_HDR      = 8'h55;
    localparam logic [7:0] WT931_TYPE_ACC = 8'h51;
    localparam logic [7:0] WT931_TYPE_GYR = 8'h52;
    localparam logic [7:0] WT931_TYPE_ANG = 8'h53;
    localparam logic [7:0] WT931_TYPE_MAG = 8'h54;

    localparam int unsigned WT931_FRAME_LEN   = 11;
    localparam int unsigned WT931_PAYLOAD_LEN = WT931_FRAME_LEN - 2;
    localparam int unsigned WT931_BEATS       = 4;

    typedef enum logic [1:0] {
        HUNT,
        COLLECT,
        CHECK,
        WRITE
    } wt931_state_e;

    // TYPE byte plus the eight data bytes; data[k] holds Dk
    typedef struct packed {
        logic [7:0][7:0] data;
        logic [7:0]      ftype;
    } wt931_frame_t;

    function automatic logic [31:0] field_ext(input logic [7:0] lo,
                                              input logic [7:0] hi,
                                              input logic       sign);
        logic [15:0] raw;
        raw = {hi, lo};
        return sign ? {{16{raw[15]}}, raw} : {16'h0000, raw};
    endfunction

    function automatic logic type_supported(input logic [7:0] ftype);
        return (ftype == WT931_TYPE_ACC) || (ftype == WT931_TYPE_GYR) ||
               (ftype == WT931_TYPE_ANG) || (ftype == WT931_TYPE_MAG);
    endfunction

endpackage

// File: rtl/wt931_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module wt931_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/wt931_frame_ctrl.sv
// WT931 frame controller: hunts 0x55 headers in the RX byte stream, checks the
// frame sum and writes the four decoded fields into the register bank.
// Optional inter-byte timeout enabled by defining WT931_TIMEOUT_EN.
module wt931_frame_ctrl
    import wt931_pkg::*;
#(
    parameter int unsigned ADDR_W      = 4,
    parameter bit          SIGN_EXT    = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              enable,
    input  logic              s_byte_valid,
    input  logic [7:0]        s_byte_data,
    output logic              s_byte_ready,
    output logic              reg_wr_valid,
    input  logic              reg_wr_ready,
    output logic [ADDR_W-1:0] reg_wr_addr,
    output logic [31:0]       reg_wr_data,
    output logic              frame_done,
    output logic [15:0]       frame_ok_cnt,
    output logic [15:0]       frame_err_cnt,
    output logic              busy
);

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned BEAT_W = 2;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WT931_PAYLOAD_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WT931_BEATS - 1);

    wt931_state_e       state_q, state_d;
    wt931_frame_t       frame_q, frame_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         sum_q, sum_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [31:0]        data_d;
    logic               done_d;
    logic               ok_inc_c;
    logic               err_inc_c;
    logic               byte_fire_c;
    logic               wr_fire_c;
    logic               timeout_c;

    assign byte_fire_c = s_byte_valid && s_byte_ready;
    assign wr_fire_c   = reg_wr_valid && reg_wr_ready;

    function automatic logic [31:0] field_sel(input wt931_frame_t      f,
                                              input logic [BEAT_W-1:0] k);
        return field_ext(f.data[{k, 1'b0}], f.data[{k, 1'b1}], SIGN_EXT);
    endfunction

    // Each sensor TYPE owns a group of four consecutive registers
    function automatic logic [ADDR_W-1:0] addr_sel(input logic [7:0]        ftype,
                                                   input logic [BEAT_W-1:0] k);
        logic [1:0] bank;
        bank = 2'(ftype - WT931_TYPE_ACC);
        return ADDR_W'({bank, k});
    endfunction

`ifdef WT931_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_q;

    // Idle-cycle counter while a frame is open; any accepted byte restarts it
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            to_q <= '0;
        end else if (byte_fire_c || timeout_c || !(state_q inside {COLLECT, CHECK})) begin
            to_q <= '0;
        end else begin
            to_q <= to_q + TO_W'(1);
        end
    end

    assign timeout_c = (state_q inside {COLLECT, CHECK}) && !byte_fire_c &&
                       (to_q == TO_W'(TIMEOUT_CYC));
`else
    // Timeout disabled: a stalled frame waits indefinitely
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
    assign timeout_c          = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        beat_d    = beat_q;
        addr_d    = reg_wr_addr;
        data_d    = reg_wr_data;
        done_d    = 1'b0;
        ok_inc_c  = 1'b0;
        err_inc_c = 1'b0;

        case (state_q)
            HUNT: begin
                idx_d = '0;
                if (enable && byte_fire_c && (s_byte_data == WT931_HDR)) begin
                    state_d = COLLECT;
                    sum_d   = WT931_HDR;
                end
            end

            COLLECT: begin
                if (!enable) begin
                    state_d = HUNT;
                end else if (byte_fire_c) begin
                    if (idx_q == '0) begin
                        frame_d.ftype = s_byte_data;
                    end else begin
                        frame_d.data[3'(idx_q - IDX_W'(1))] = s_byte_data;
                    end
                    sum_d = sum_q + s_byte_data;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = CHECK;
                    end
                end else if (timeout_c) begin
                    err_inc_c = 1'b1;
                    state_d   = HUNT;
                end
            end

            CHECK: begin
                if (!enable) begin
                    state_d = HUNT;
                end else if (byte_fire_c) begin
                    if (s_byte_data != sum_q) begin
                        err_inc_c = 1'b1;
                        state_d   = HUNT;
                    end else if (type_supported(frame_q.ftype)) begin
                        ok_inc_c = 1'b1;
                        state_d  = WRITE;
                        beat_d   = '0;
                        addr_d   = addr_sel(frame_q.ftype, BEAT_W'(0));
                        data_d   = field_sel(frame_q, BEAT_W'(0));
                    end else begin
                        state_d = HUNT;
                    end
                end else if (timeout_c) begin
                    err_inc_c = 1'b1;
                    state_d   = HUNT;
                end
            end

            WRITE: begin
                // enable is ignored here so a register group is never left half-written
                if (wr_fire_c) begin
                    if (beat_q == BEAT_LAST) begin
                        done_d  = 1'b1;
                        state_d = HUNT;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        addr_d = addr_sel(frame_q.ftype, beat_d);
                        data_d = field_sel(frame_q, beat_d);
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State, datapath and registered output decode from the next state
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= HUNT;
            frame_q      <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            beat_q       <= '0;
            s_byte_ready <= 1'b1;
            reg_wr_valid <= 1'b0;
            reg_wr_addr  <= '0;
            reg_wr_data  <= '0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            beat_q       <= beat_d;
            s_byte_ready <= (state_d != WRITE);
            reg_wr_valid <= (state_d == WRITE);
            reg_wr_addr  <= addr_d;
            reg_wr_data  <= data_d;
            frame_done   <= done_d;
            busy         <= (state_d != HUNT);
        end
    end

    wt931_sat_counter #(.W(16)) u_ok_cnt (
        .clk (ACLK),
        .rst (ARESET),
        .inc (ok_inc_c),
        .cnt (frame_ok_cnt)
    );

    wt931_sat_counter #(.W(16)) u_err_cnt (
        .clk (ACLK),
        .rst (ARESET),
        .inc (err_inc_c),
        .cnt (frame_err_cnt)
    );

endmodule

// File: tb/tb_wt931_frame_ctrl.sv
// Self-checking bench for wt931_frame_ctrl: directed scenarios plus randomized
// frames scored against a byte-level frame model.
module tb_wt931_frame_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned TO_CYC = 50;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              enable;
    logic              s_byte_valid;
    logic [7:0]        s_byte_data;
    logic              s_byte_ready;
    logic              reg_wr_valid;
    logic              reg_wr_ready;
    logic [ADDR_W-1:0] reg_wr_addr;
    logic [31:0]       reg_wr_data;
    logic              frame_done;
    logic [15:0]       frame_ok_cnt;
    logic [15:0]       frame_err_cnt;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    logic [35:0] exp_q[$];
    logic [35:0] log_q[$];
    logic [7:0]  mbuf[$];
    int          exp_ok   = 0;
    int          exp_err  = 0;
    int          exp_done = 0;
    int          got_done = 0;

    bit   ready_mode  = 1'b0;
    logic ready_force = 1'b1;
    logic ready_rnd   = 1'b1;

    always #5 ACLK = ~ACLK;

    assign reg_wr_ready = ready_mode ? ready_rnd : ready_force;

    always @(posedge ACLK) begin
        #1;
        ready_rnd = 1'($urandom_range(0, 1));
    end

    wt931_frame_ctrl #(
        .ADDR_W      (ADDR_W),
        .SIGN_EXT    (1'b1),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .enable        (enable),
        .s_byte_valid  (s_byte_valid),
        .s_byte_data   (s_byte_data),
        .s_byte_ready  (s_byte_ready),
        .reg_wr_valid  (reg_wr_valid),
        .reg_wr_ready  (reg_wr_ready),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .frame_done    (frame_done),
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt),
        .busy          (busy)
    );

    // Scoreboard: every accepted register write must match the model's next entry
    always @(negedge ACLK) begin
        if (ARESET === 1'b0) begin
            if (reg_wr_valid === 1'b1 && reg_wr_ready === 1'b1) begin
                log_q.push_back({reg_wr_addr, reg_wr_data});
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected got addr=%0d data=%h expected no write",
                             reg_wr_addr, reg_wr_data);
                end else begin
                    logic [35:0] e;
                    e = exp_q.pop_front();
                    if ({reg_wr_addr, reg_wr_data} !== e) begin
                        failures++;
                        $display("FAIL wr_beat got addr=%0d data=%h expected addr=%0d data=%h",
                                 reg_wr_addr, reg_wr_data, e[35:32], e[31:0]);
                    end
                end
            end
            if (frame_done === 1'b1) got_done++;
        end
    end

    // Frame model: a frame is 0x55 plus ten more bytes; judged once complete
    function automatic void model_byte(input logic [7:0] b);
        int s;
        int t;
        int v;
        if (mbuf.size() == 0 && b != 8'h55) return;
        mbuf.push_back(b);
        if (mbuf.size() < 11) return;
        s = 0;
        for (int i = 0; i < 10; i++) s += int'(mbuf[i]);
        t = int'(mbuf[1]);
        if ((s % 256) != int'(mbuf[10])) begin
            if (exp_err < 65535) exp_err++;
        end else if (t >= 'h51 && t <= 'h54) begin
            if (exp_ok < 65535) exp_ok++;
            exp_done++;
            for (int k = 0; k < 4; k++) begin
                v = int'(mbuf[2 + 2*k]) + 256 * int'(mbuf[3 + 2*k]);
                if (v >= 32768) v -= 65536;
                exp_q.push_back({4'((t - 'h51) * 4 + k), 32'(v)});
            end
        end
        mbuf.delete();
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        s_byte_valid = 1'b1;
        s_byte_data  = b;
        while (!acc) begin
            @(negedge ACLK);
            if (s_byte_ready === 1'b1) acc = 1'b1;
            @(posedge ACLK);
            #1;
            n++;
            if (!acc && n > 200) begin
                checks++;
                failures++;
                $display("FAIL byte_accept got no ready in %0d cycles expected acceptance", n);
                s_byte_valid = 1'b0;
                return;
            end
        end
        s_byte_valid = 1'b0;
        if (enable) model_byte(b);
    endtask

    task automatic send_frame(input logic [7:0] ftype, input logic [63:0] d,
                              input logic [7:0] sum_xor);
        logic [7:0] s;
        s = 8'h55 + ftype;
        for (int k = 0; k < 8; k++) s = s + d[8*k +: 8];
        send_byte(8'h55);
        send_byte(ftype);
        for (int k = 0; k < 8; k++) send_byte(d[8*k +: 8]);
        send_byte(s ^ sum_xor);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while ((busy !== 1'b0 || exp_q.size() != 0) && n < 300);
        @(posedge ACLK);
        #1;
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL wait_idle got busy=%b pending=%0d expected idle", busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        idle(3);
        @(negedge ACLK);
        checks += 6;
        if (s_byte_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got %b expected 1", s_byte_ready); end
        if (reg_wr_valid !== 1'b0) begin failures++; $display("FAIL rst_wr_valid got %b expected 0", reg_wr_valid); end
        if ({reg_wr_addr, reg_wr_data} !== 36'd0) begin failures++; $display("FAIL rst_wr_bus got %h expected 0", {reg_wr_addr, reg_wr_data}); end
        if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_done got %b expected 0", frame_done); end
        if ({frame_ok_cnt, frame_err_cnt} !== 32'd0) begin failures++; $display("FAIL rst_cnts got %h expected 0", {frame_ok_cnt, frame_err_cnt}); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b expected 0", busy); end
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        idle(2);
        checks++;
        if (s_byte_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_rst got ready=%b busy=%b expected ready=1 busy=0", s_byte_ready, busy);
        end
    endtask

    task automatic test_good_frame();
        ready_force = 1'b1;
        send_frame(8'h51, 64'h0040_0030_0020_0010, 8'h00);
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            checks++;
            if (reg_wr_valid !== 1'b1 || reg_wr_addr !== 4'(k) ||
                reg_wr_data !== 32'((k + 1) * 16) || s_byte_ready !== 1'b0) begin
                failures++;
                $display("FAIL good_beat%0d got v=%b a=%0d d=%h rdy=%b expected v=1 a=%0d d=%h rdy=0",
                         k, reg_wr_valid, reg_wr_addr, reg_wr_data, s_byte_ready, k, (k + 1) * 16);
            end
        end
        @(negedge ACLK);
        checks++;
        if (frame_done !== 1'b1 || reg_wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL good_done got done=%b valid=%b expected done=1 valid=0", frame_done, reg_wr_valid);
        end
        @(negedge ACLK);
        checks += 2;
        if (frame_done !== 1'b0) begin failures++; $display("FAIL done_pulse got %b expected 0", frame_done); end
        if (frame_ok_cnt !== 16'd1) begin failures++; $display("FAIL good_ok_cnt got %0d expected 1", frame_ok_cnt); end
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_neg_gyro();
        logic [35:0] want[4];
        int start;
        want[0] = {4'd4, 32'hFFFF_FFFF};
        want[1] = {4'd5, 32'hFFFF_8000};
        want[2] = {4'd6, 32'h0000_0000};
        want[3] = {4'd7, 32'h0000_0000};
        start = log_q.size();
        send_frame(8'h52, 64'h0000_0000_8000_FFFF, 8'h00);
        wait_idle();
        checks++;
        if (log_q.size() - start != 4) begin
            failures++;
            $display("FAIL gyro_count got %0d writes expected 4", log_q.size() - start);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (log_q[start + k] !== want[k]) begin
                    failures++;
                    $display("FAIL gyro_beat%0d got %h expected %h", k, log_q[start + k], want[k]);
                end
            end
        end
    endtask

    task automatic test_noise_bad_sum();
        int start;
        start = log_q.size();
        send_byte(8'h00);
        send_byte(8'hAA);
        send_frame(8'h51, 64'h0040_0030_0020_0010, 8'h00);
        wait_idle();
        checks++;
        if (log_q.size() - start != 4) begin
            failures++;
            $display("FAIL noise_count got %0d writes expected 4", log_q.size() - start);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (log_q[start + k] !== {4'(k), 32'((k + 1) * 16)}) begin
                    failures++;
                    $display("FAIL noise_beat%0d got %h expected %h", k, log_q[start + k], {4'(k), 32'((k + 1) * 16)});
                end
            end
        end
        start = log_q.size();
        send_frame(8'h51, 64'h0040_0030_0020_0010, 8'h01);
        idle(8);
        checks += 3;
        if (log_q.size() != start) begin failures++; $display("FAIL badsum_writes got %0d expected 0", log_q.size() - start); end
        if (frame_err_cnt !== 16'd1) begin failures++; $display("FAIL badsum_err_cnt got %0d expected 1", frame_err_cnt); end
        if (frame_ok_cnt !== 16'(exp_ok)) begin failures++; $display("FAIL badsum_ok_cnt got %0d expected %0d", frame_ok_cnt, exp_ok); end
    endtask

    task automatic test_backpressure();
        logic [35:0] want[4];
        int start;
        want[0] = {4'd8,  32'h0000_2211};
        want[1] = {4'd9,  32'h0000_4433};
        want[2] = {4'd10, 32'h0000_6655};
        want[3] = {4'd11, 32'hFFFF_8877};
        start = log_q.size();
        ready_force = 1'b1;
        send_frame(8'h53, 64'h8877_6655_4433_2211, 8'h00);
        @(posedge ACLK);
        #1;
        ready_force = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            checks++;
            if (reg_wr_valid !== 1'b1 || {reg_wr_addr, reg_wr_data} !== want[1] || s_byte_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%b bus=%h rdy=%b expected v=1 bus=%h rdy=0",
                         i, reg_wr_valid, {reg_wr_addr, reg_wr_data}, s_byte_ready, want[1]);
            end
            @(posedge ACLK);
            #1;
        end
        ready_force = 1'b1;
        wait_idle();
        checks++;
        if (log_q.size() - start != 4) begin
            failures++;
            $display("FAIL bp_count got %0d writes expected 4", log_q.size() - start);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (log_q[start + k] !== want[k]) begin
                    failures++;
                    $display("FAIL bp_beat%0d got %h expected %h", k, log_q[start + k], want[k]);
                end
            end
        end
    endtask

    task automatic test_unsupported();
        int start;
        start = log_q.size();
        send_frame(8'h5A, 64'h0102_0304_0506_0708, 8'h00);
        idle(8);
        checks += 3;
        if (log_q.size() != start) begin failures++; $display("FAIL unsup_writes got %0d expected 0", log_q.size() - start); end
        if (frame_ok_cnt !== 16'd4) begin failures++; $display("FAIL unsup_ok_cnt got %0d expected 4", frame_ok_cnt); end
        if (frame_err_cnt !== 16'd1) begin failures++; $display("FAIL unsup_err_cnt got %0d expected 1", frame_err_cnt); end
    endtask

    task automatic test_abort();
        logic [7:0] part[6];
        int start;
        part = '{8'h55, 8'h51, 8'h10, 8'h00, 8'h20, 8'h00};
        start = log_q.size();
        for (int i = 0; i < 6; i++) send_byte(part[i]);
        enable = 1'b0;
        idle(2);
        mbuf.delete();
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got %b expected 0", busy); end
        if (frame_ok_cnt !== 16'(exp_ok) || frame_err_cnt !== 16'(exp_err)) begin
            failures++;
            $display("FAIL abort_cnts got ok=%0d err=%0d expected ok=%0d err=%0d", frame_ok_cnt, frame_err_cnt, exp_ok, exp_err);
        end
        if (log_q.size() != start) begin failures++; $display("FAIL abort_writes got %0d expected 0", log_q.size() - start); end
        enable = 1'b1;
        idle(1);
        start = log_q.size();
        send_frame(8'h54, 64'h0807_0605_0403_0201, 8'h00);
        enable = 1'b0;
        wait_idle();
        enable = 1'b1;
        checks += 2;
        if (log_q.size() - start != 4) begin failures++; $display("FAIL en_low_write got %0d writes expected 4", log_q.size() - start); end
        if (got_done != exp_done) begin failures++; $display("FAIL en_low_done got %0d expected %0d", got_done, exp_done); end
    endtask

    task automatic test_stall();
        int start;
        start = log_q.size();
        send_byte(8'h55);
        send_byte(8'h51);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        idle(60);
`ifdef WT931_TIMEOUT_EN
        mbuf.delete();
        if (exp_err < 65535) exp_err++;
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy got %b expected 0", busy); end
        if (frame_err_cnt !== 16'(exp_err)) begin failures++; $display("FAIL timeout_err_cnt got %0d expected %0d", frame_err_cnt, exp_err); end
`else
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy got %b expected 1", busy); end
        send_byte(8'h04);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h08);
        send_byte(8'hCA);
        wait_idle();
        checks++;
        if (log_q.size() - start != 4) begin failures++; $display("FAIL stall_writes got %0d expected 4", log_q.size() - start); end
`endif
    endtask

    task automatic test_random();
        logic [7:0]  ftype;
        logic [63:0] d;
        logic [7:0]  nb;
        int kind;
        ready_mode = 1'b1;
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) begin
                nb = 8'($urandom);
                if (nb == 8'h55) nb = 8'h56;
                send_byte(nb);
            end
            kind = int'($urandom_range(0, 9));
            d    = {32'($urandom), 32'($urandom)};
            if (kind == 8) begin
                ftype = 8'($urandom);
                if (ftype >= 8'h51 && ftype <= 8'h54) ftype = 8'h60;
            end else begin
                ftype = 8'(8'h51 + $urandom_range(0, 3));
            end
            send_frame(ftype, d, (kind == 7) ? 8'($urandom_range(1, 255)) : 8'h00);
            idle(int'($urandom_range(0, 3)));
        end
        wait_idle();
        ready_mode = 1'b0;
        checks += 3;
        if (frame_ok_cnt !== 16'(exp_ok)) begin failures++; $display("FAIL rand_ok_cnt got %0d expected %0d", frame_ok_cnt, exp_ok); end
        if (frame_err_cnt !== 16'(exp_err)) begin failures++; $display("FAIL rand_err_cnt got %0d expected %0d", frame_err_cnt, exp_err); end
        if (got_done != exp_done) begin failures++; $display("FAIL rand_done got %0d expected %0d", got_done, exp_done); end
    endtask

    task automatic test_reset_mid_write();
        ready_force = 1'b1;
        send_frame(8'h51, 64'h0040_0030_0020_0010, 8'h00);
        idle(2);
        #1;
        ARESET = 1'b1;
        #1;
        checks += 3;
        if (reg_wr_valid !== 1'b0) begin failures++; $display("FAIL arst_wr_valid got %b expected 0", reg_wr_valid); end
        if (s_byte_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL arst_ready_busy got ready=%b busy=%b expected ready=1 busy=0", s_byte_ready, busy);
        end
        if ({frame_ok_cnt, frame_err_cnt} !== 32'd0) begin failures++; $display("FAIL arst_cnts got %h expected 0", {frame_ok_cnt, frame_err_cnt}); end
        exp_q.delete();
        mbuf.delete();
        exp_ok   = 0;
        exp_err  = 0;
        exp_done = 0;
        got_done = 0;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        idle(1);
        send_frame(8'h52, 64'h1111_2222_3333_4444, 8'h00);
        wait_idle();
        checks += 2;
        if (frame_ok_cnt !== 16'd1) begin failures++; $display("FAIL arst_recover_ok got %0d expected 1", frame_ok_cnt); end
        if (got_done != 1) begin failures++; $display("FAIL arst_recover_done got %0d expected 1", got_done); end
    endtask

    initial begin
        ARESET       = 1'b1;
        enable       = 1'b1;
        s_byte_valid = 1'b0;
        s_byte_data  = 8'h00;
        test_reset();
        test_good_frame();
        test_neg_gyro();
        test_noise_bad_sum();
        test_backpressure();
        test_unsupported();
        test_abort();
        test_stall();
        test_random();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog got no completion expected finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wt931_frame_ctrl.md
Name: wt931_frame_ctrl

Overview:
Controller that sequences the WT931 IMU decode datapath. It consumes the UART RX byte stream, hunts for the 0x55 header and collects 11-byte WitMotion frames. It verifies the checksum, then schedules up to four 32-bit writes per frame into the shared decoder register bank. The write port is valid/ready, so the bank-side arbiter can give AXI4-Lite slave writes priority.

Parameters:
ADDR_W, 4, register-bank word address width; 16 data registers.
SIGN_EXT, 1, 1 = sign-extend int16 fields to 32 bits; 0 = zero-extend.
TIMEOUT_CYC, 100000, inter-byte timeout in ACLK cycles. Used only with WT931_TIMEOUT_EN.

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
enable  in  1  parser enable
s_byte_valid  in  1  RX byte valid
s_byte_data  in  8  RX byte
s_byte_ready  out  1  byte accepted when valid && ready
reg_wr_valid  out  1  register write request
reg_wr_ready  in  1  bank accepts write
reg_wr_addr  out  ADDR_W  register index
reg_wr_data  out  32  register data
frame_done  out  1  1-cycle pulse after the last write beat of a frame is accepted
frame_ok_cnt  out  16  good frames, saturating
frame_err_cnt  out  16  checksum/timeout failures, saturating
busy  out  1  state != HUNT

Behaviour:
- Reset values: all outputs 0, except s_byte_ready = 1. State = HUNT; byte buffer and checksum accumulator cleared.
- Frame format: 0x55, TYPE, D0..D7, SUM.
  - SUM = low 8 bits of the sum of the first 10 bytes.
  - Field i (0..3) = {D(2i+1), D(2i)}, little-endian, extended per SIGN_EXT.
- s_byte_ready = 1 in every state except WRITE.
- States:
  - HUNT: accepted byte == 0x55 -> COLLECT, accumulator = 0x55. Any other byte is discarded.
  - COLLECT: accepts 9 bytes (TYPE, D0..D7) into buffer and accumulator; 0x55 here is data, not a header. After D7 -> CHECK.
  - CHECK: the next accepted byte is SUM.
    - Mismatch -> frame_err_cnt += 1, -> HUNT.
    - Match, TYPE in 0x51..0x54 -> frame_ok_cnt += 1, -> WRITE, beat = 0.
    - Match, any other TYPE -> -> HUNT; no write, counters unchanged.
  - WRITE: reg_wr_valid = 1, reg_wr_addr = (TYPE - 0x51)*4 + beat, reg_wr_data = field[beat].
    - Addr/data are held stable until reg_wr_ready.
    - One beat per handshake. After beat 3 is accepted: frame_done pulses for 1 cycle, -> HUNT.
- Latency: SUM accepted in cycle N -> first reg_wr_valid in N+1. With reg_wr_ready tied high, 4 beats occupy N+1..N+4 and frame_done is asserted in N+5.
- enable low:
  - Bytes are still accepted and discarded.
  - In COLLECT or CHECK: abort to HUNT in the next cycle, no counter change.
  - In WRITE: the remaining beats complete, so no torn register set.
  - Parser stays in HUNT while enable is low.
- Counters saturate at 0xFFFF, no wrap.
- A byte handshake and a write handshake never occur in the same cycle, because ready is gated by WRITE.
- ARESET asserted mid-frame or mid-WRITE: outputs drop to reset values immediately (asynchronous); the partial frame is lost.

Optional Feature:
WT931_TIMEOUT_EN
- Defined:
  - A counter runs in COLLECT and CHECK and clears on every accepted byte.
  - When it reaches TIMEOUT_CYC: frame_err_cnt += 1, -> HUNT.
  - A byte accepted in the same cycle as the timeout takes priority and the timeout is not taken.
- Undefined: no counter; a stalled frame waits indefinitely.

Decomposition:
- Package wt931_pkg holds:
  - constants WT931_HDR = 8'h55, WT931_TYPE_ACC = 8'h51, WT931_TYPE_GYR = 8'h52, WT931_TYPE_ANG = 8'h53, WT931_TYPE_MAG = 8'h54, WT931_FRAME_LEN = 11;
  - state enum {HUNT, COLLECT, CHECK, WRITE};
  - function field_ext(lo, hi, sign).
- Sub-module wt931_sat_counter (16-bit saturating increment), instantiated twice.

Test Plan:
- Good frame: 55 51 10 00 20 00 30 00 40 00 46, ready high -> writes (0,0x10), (1,0x20), (2,0x30), (3,0x40) on consecutive cycles; frame_done pulses once; ok_cnt = 1.
- Negative gyro with SIGN_EXT=1: 55 52 FF FF 00 80 00 00 00 00 + correct SUM -> writes (4,0xFFFFFFFF), (5,0xFFFF8000), (6,0), (7,0).
- Noise and bad SUM:
  - 00 AA 55 51 10 00 20 00 30 00 40 00 46 -> same writes as the good frame.
  - Good frame with SUM 0x47 -> no writes, err_cnt = 1.
- Backpressure: reg_wr_ready low 3 cycles on beat 1 -> addr/data held, s_byte_ready = 0 throughout, no beat lost or duplicated.
- Unsupported TYPE 0x5A with valid SUM -> no writes, both counters unchanged.
- Abort, reset and timeout:
  - enable dropped after D3 -> HUNT, no counters change.
  - ARESET during beat 2 -> reg_wr_valid = 0 immediately.
  - With WT931_TIMEOUT_EN and TIMEOUT_CYC = 50, a 60-cycle gap mid-frame -> err_cnt += 1.
